// File: rtl/alu_arbiter_if.sv
// alu_arbiter bus: two request/response channels plus the shared ALU side.
// slave = arbiter view, master = requesters + ALU view.
interface alu_arbiter_if #(
  parameter int DATAWIDTH  = 32,
  parameter int CTRLWIDTH  = 4,
  parameter int BCTRLWIDTH = 3
);
  logic                  req0_valid_i;
  logic                  req0_ready_o;
  logic [DATAWIDTH-1:0]  req0_a_i;
  logic [DATAWIDTH-1:0]  req0_b_i;
  logic [CTRLWIDTH-1:0]  req0_ctrl_i;
  logic [BCTRLWIDTH-1:0] req0_bctrl_i;
  logic                  req1_valid_i;
  logic                  req1_ready_o;
  logic [DATAWIDTH-1:0]  req1_a_i;
  logic [DATAWIDTH-1:0]  req1_b_i;
  logic [CTRLWIDTH-1:0]  req1_ctrl_i;
  logic [BCTRLWIDTH-1:0] req1_bctrl_i;
  logic                  rsp0_valid_o;
  logic                  rsp0_ready_i;
  logic [DATAWIDTH-1:0]  rsp0_result_o;
  logic                  rsp0_branch_o;
  logic                  rsp1_valid_o;
  logic                  rsp1_ready_i;
  logic [DATAWIDTH-1:0]  rsp1_result_o;
  logic                  rsp1_branch_o;
  logic [DATAWIDTH-1:0]  alu_srca_o;
  logic [DATAWIDTH-1:0]  alu_srcb_o;
  logic [CTRLWIDTH-1:0]  alu_ctrl_o;
  logic [BCTRLWIDTH-1:0] alu_bctrl_o;
  logic [DATAWIDTH-1:0]  alu_result_i;
  logic                  alu_branch_i;
  logic                  busy_o;

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i,
    input  req0_ctrl_i, req0_bctrl_i,
    input  req1_valid_i, req1_a_i, req1_b_i,
    input  req1_ctrl_i, req1_bctrl_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_result_o, rsp0_branch_o,
    output rsp1_valid_o, rsp1_result_o, rsp1_branch_o,
    input  rsp0_ready_i, rsp1_ready_i,
    output alu_srca_o, alu_srcb_o, alu_ctrl_o, alu_bctrl_o,
    input  alu_result_i, alu_branch_i,
    output busy_o
  );

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i,
    output req0_ctrl_i, req0_bctrl_i,
    output req1_valid_i, req1_a_i, req1_b_i,
    output req1_ctrl_i, req1_bctrl_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_result_o, rsp0_branch_o,
    input  rsp1_valid_o, rsp1_result_o, rsp1_branch_o,
    output rsp0_ready_i, rsp1_ready_i,
    input  alu_srca_o, alu_srcb_o, alu_ctrl_o, alu_bctrl_o,
    output alu_result_i, alu_branch_i,
    input  busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Ports: clk_i, rst_i (sync, active-high), bus (alu_arbiter_if.slave).
module alu_arbiter #(
  parameter int DATAWIDTH  = 32,
  parameter int CTRLWIDTH  = 4,
  parameter int BCTRLWIDTH = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  ptr_q;
  logic                  owner_q;
  logic [DATAWIDTH-1:0]  a_q;
  logic [DATAWIDTH-1:0]  b_q;
  logic [CTRLWIDTH-1:0]  ctrl_q;
  logic [BCTRLWIDTH-1:0] bctrl_q;
  logic [DATAWIDTH-1:0]  res_q;
  logic                  br_q;

  logic idle;
  logic gnt0;
  logic gnt1;
  logic req_hs;
  logic rsp_hs;

  always_comb begin
    // reset masks grants so nothing is accepted during the reset cycle
    idle   = (state_q == IDLE) & ~rst_i;
    gnt0   = idle & bus.req0_valid_i
           & (~bus.req1_valid_i | ~ptr_q);
    gnt1   = idle & bus.req1_valid_i
           & (~bus.req0_valid_i | ptr_q);
    req_hs = gnt0 | gnt1;
    rsp_hs = (state_q == RESP)
           & (owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i);
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      bctrl_q <= '1;
      res_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        owner_q <= gnt1;
        ptr_q   <= gnt0;
        a_q     <= gnt1 ? bus.req1_a_i     : bus.req0_a_i;
        b_q     <= gnt1 ? bus.req1_b_i     : bus.req0_b_i;
        ctrl_q  <= gnt1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
        bctrl_q <= gnt1 ? bus.req1_bctrl_i : bus.req0_bctrl_i;
      end
      if (state_q == EXEC) begin
        res_q <= bus.alu_result_i;
        br_q  <= bus.alu_branch_i;
      end
    end
  end

  assign bus.req0_ready_o  = gnt0;
  assign bus.req1_ready_o  = gnt1;
  assign bus.rsp0_valid_o  = (state_q == RESP) & ~owner_q;
  assign bus.rsp1_valid_o  = (state_q == RESP) & owner_q;
  assign bus.rsp0_result_o = res_q;
  assign bus.rsp1_result_o = res_q;
  assign bus.rsp0_branch_o = br_q;
  assign bus.rsp1_branch_o = br_q;
  assign bus.alu_srca_o    = a_q;
  assign bus.alu_srcb_o    = b_q;
  assign bus.alu_ctrl_o    = ctrl_q;
  assign bus.alu_bctrl_o   = bctrl_q;
  assign bus.busy_o        = (state_q != IDLE);
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single combinational ALU between two requesters: requester 0 is the core execute stage, requester 1 is an auxiliary unit such as an address-generation or debug engine.
- Each requester has a valid/ready request channel carrying operands and ALU/branch control codes, and a valid/ready response channel returning the result and branch flag.
- Grants are round-robin. One operation is in flight at a time.
- The block drives the ALU operand and control inputs and samples the ALU result and branch outputs.

Parameters:
- DATAWIDTH, 32, operand/result width.
- CTRLWIDTH, 4, ALU operation code width.
- BCTRLWIDTH, 3, branch-compare code width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 is granted this cycle.
- req0_a_i  in  DATAWIDTH  operand A.
- req0_b_i  in  DATAWIDTH  operand B.
- req0_ctrl_i  in  CTRLWIDTH  ALU op code.
- req0_bctrl_i  in  BCTRLWIDTH  branch code.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_ctrl_i, req1_bctrl_i  as above for requester 1.
- rsp0_valid_o  out  1  result for requester 0 available.
- rsp0_ready_i  in  1  requester 0 accepts the result.
- rsp0_result_o  out  DATAWIDTH  captured ALU result.
- rsp0_branch_o  out  1  captured branch flag.
- rsp1_valid_o, rsp1_ready_i, rsp1_result_o, rsp1_branch_o  as above for requester 1.
- alu_srca_o  out  DATAWIDTH  to ALU SrcA.
- alu_srcb_o  out  DATAWIDTH  to ALU SrcB.
- alu_ctrl_o  out  CTRLWIDTH  to ALU op control.
- alu_bctrl_o  out  BCTRLWIDTH  to ALU branch control.
- alu_result_i  in  DATAWIDTH  ALU result.
- alu_branch_i  in  1  ALU branch flag.
- busy_o  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_i is synchronous and active-high and overrides all other inputs in the same cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready_o is combinational and asserted only for the granted requester, and only when its valid is high.
  - At most one ready is high in any cycle.
  - Ready never depends on any rsp*_ready_i.
- Arbitration:
  - A priority pointer holds the preferred requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's requester is granted.
  - On every handshake the pointer moves to the other requester.
  - The reset value of the pointer favours requester 0.
- Handshake (valid & ready at edge T):
  - Latch A, B, ctrl, bctrl and owner ID into the operand registers.
  - FSM goes to EXEC.
- EXEC (cycle T+1):
  - alu_*_o are driven from the operand registers for the whole cycle.
  - At the end of the cycle, capture alu_result_i and alu_branch_i into the result registers.
  - FSM goes to RESP.
- RESP (from cycle T+2):
  - rspN_valid_o is high for the owner only; the other rsp valid is low.
  - rspN_result_o and rspN_branch_o hold the captured values and stay stable until the handshake.
  - On rspN_valid_o & rspN_ready_i, the FSM returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
  - Latency from request handshake to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles.
  - If rsp ready stays low, the FSM stays in RESP indefinitely; both req readys stay low and the result holds.
- ALU outputs:
  - alu_*_o always reflect the operand registers, including outside EXEC.
  - The registers change only on a request handshake.
- Response outputs:
  - rsp*_result_o and rsp*_branch_o of both channels are driven from the shared result registers.
  - Only the owner's valid qualifies them.
- Reset values:
  - FSM = IDLE; pointer = 0; owner = 0.
  - Operand registers: A = 0, B = 0, ctrl = 0, bctrl = all-ones (no-branch code).
  - Result = 0, branch = 0.
  - All valid/ready outputs = 0 and busy_o = 0, once the cycle after reset completes.
- Reset mid-operation (EXEC or RESP):
  - Drops the in-flight operation; no response is issued.
  - The FSM is in IDLE the following cycle.
- Requester rules:
  - Inputs of a non-granted requester are ignored and not latched.
  - A requester may drop valid before being granted without side effects.
- Widths: no arithmetic inside the block; all data paths are pass-through at the parameter widths.

Test Plan:
- Single request: req0 A=5, B=3, ctrl=0001, with a reference ALU attached → req0_ready_o=1 in the request cycle; rsp0_valid_o=1 two cycles later with result=2; rsp1_valid_o=0 throughout.
- Contention: both requesters continuously valid for 4 ops, rsp ready tied high → grant order 0,1,0,1; each response reaches the correct channel; issue interval exactly 3 cycles.
- Response backpressure: rsp1_ready_i held low for 5 cycles → rsp1_valid_o held; result stable; req0_ready_o=0 throughout even with req0_valid_i=1; busy_o=1.
- Branch path: req1 A=-1, B=1, bctrl=010 (signed <) → rsp1_branch_o=1. Same operands with bctrl=100 (unsigned <) → rsp1_branch_o=0.
- Reset in EXEC and in RESP: assert rst_i for one cycle → no rsp valid afterwards; busy_o=0; next req0-only request is accepted immediately and pointer favours req0.
- Pointer fairness: req1-only op, then both valid → next grant goes to req0; operands of the non-granted requester never appear on alu_srca_o.
